// File: rtl/mult_div_unit_pkg.sv
// Shared opcodes, latency defaults and the combinational mult/div arithmetic
// for the E-stage multiply/divide unit.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_MTLO  = 3'b000,
        MD_MTHI  = 3'b001,
        MD_MULT  = 3'b010,
        MD_MULTU = 3'b011,
        MD_DIV   = 3'b100,
        MD_DIVU  = 3'b101
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MD_MULT_CYC = 5;
    localparam int MD_DIV_CYC  = 10;

    // wr=0 means the operation completes without touching HI/LO (divide by zero).
    typedef struct packed {
        logic        wr;
        logic [31:0] hi;
        logic [31:0] lo;
    } md_result_t;

    function automatic logic is_launch_op(md_op_e op);
        return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    endfunction

    function automatic md_result_t md_compute(md_op_e op, logic [31:0] a, logic [31:0] b);
        md_result_t        r;
        logic signed [63:0] sprod;
        logic [63:0]        uprod;
        r    = '0;
        r.wr = 1'b1;
        case (op)
            MD_MULT: begin
                sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                r.hi  = sprod[63:32];
                r.lo  = sprod[31:0];
            end
            MD_MULTU: begin
                uprod = {32'b0, a} * {32'b0, b};
                r.hi  = uprod[63:32];
                r.lo  = uprod[31:0];
            end
            MD_DIV: begin
                if (b == '0) begin
                    r.wr = 1'b0;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    // The only quotient that overflows; it wraps to the dividend.
                    r.lo = a;
                    r.hi = '0;
                end else begin
                    r.lo = $signed(a) / $signed(b);
                    r.hi = $signed(a) % $signed(b);
                end
            end
            MD_DIVU: begin
                if (b == '0) begin
                    r.wr = 1'b0;
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
            default: r.wr = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Control/data bundle between the E stage and the multiply/divide unit.
interface mult_div_unit_if;
    logic        Start;
    logic [2:0]  MDOp;
    logic        MDWrite;
    logic        MDSel;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] MDOut;

    modport master (output Start, MDOp, MDWrite, MDSel, A, B, input Busy, MDOut);
    modport slave  (input Start, MDOp, MDWrite, MDSel, A, B, output Busy, MDOut);
endinterface

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: HI/LO registers, with a down-counter that
// holds results in pending registers until the modelled latency has elapsed.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYC,
    parameter int DIV_CYCLES  = MD_DIV_CYC
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave md
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    md_op_e      op;
    md_result_t  res;

    md_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;

    assign op  = md_op_e'(md.MDOp);
    assign res = md_compute(op, md.A, md.B);

    always_comb begin
        // NOTE: every _d takes its held value first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        if (state_q == ST_IDLE) begin
            // Start wins over MDWrite, so a launch never doubles as an mt* write.
            if (md.Start) begin
                if (is_launch_op(op)) begin
                    cnt_d     = (op == MD_MULT || op == MD_MULTU) ? CNT_W'(MULT_CYCLES)
                                                                  : CNT_W'(DIV_CYCLES);
                    pend_hi_d = res.hi;
                    pend_lo_d = res.lo;
                    pend_wr_d = res.wr;
                end
            end else if (md.MDWrite) begin
                if (op == MD_MTLO) lo_d = md.A;
                if (op == MD_MTHI) hi_d = md.A;
            end
        end else begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1) && pend_wr_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end

        state_d = (cnt_d != '0) ? ST_RUN : ST_IDLE;
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign md.Busy  = (state_q == ST_RUN);
    assign md.MDOut = md.MDSel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: an arithmetic reference model checked every
// cycle, plus hand-computed HI/LO/latency expectations for each scenario.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mult_div_unit_if md_if ();

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain 64-bit arithmetic, a remaining-cycle count and a pending result.
    logic [31:0] m_hi = '0, m_lo = '0, m_pend_hi = '0, m_pend_lo = '0;
    logic        m_pend_ok = 1'b0;
    int          m_left = 0;

    function automatic logic [64:0] ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      q, r;
        logic [63:0] p;
        case (op)
            3'd2: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return {1'b1, p};
            end
            3'd3: begin
                p = {32'b0, a} * {32'b0, b};
                return {1'b1, p};
            end
            3'd4: begin
                if (b == 0) return {1'b0, 64'b0};
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                return {1'b1, 32'(r), 32'(q)};
            end
            default: begin
                if (b == 0) return {1'b0, 64'b0};
                return {1'b1, a % b, a / b};
            end
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi <= '0; m_lo <= '0; m_pend_hi <= '0; m_pend_lo <= '0;
            m_pend_ok <= 1'b0; m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1 && m_pend_ok) begin
                m_hi <= m_pend_hi;
                m_lo <= m_pend_lo;
            end
        end else if (md_if.Start) begin
            if (md_if.MDOp >= 3'd2 && md_if.MDOp <= 3'd5) begin
                {m_pend_ok, m_pend_hi, m_pend_lo} <= ref_calc(md_if.MDOp, md_if.A, md_if.B);
                m_left <= (md_if.MDOp < 3'd4) ? 5 : 10;
            end
        end else if (md_if.MDWrite) begin
            if (md_if.MDOp == 3'd0) m_lo <= md_if.A;
            if (md_if.MDOp == 3'd1) m_hi <= md_if.A;
        end
    end

    // Cycle compare: Busy and MDOut against the model, away from the active edge.
    always @(negedge clk) begin
        check("cyc_busy", 32'(md_if.Busy), 32'(m_left != 0));
        check("cyc_mdout", md_if.MDOut, md_if.MDSel ? m_hi : m_lo);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic peek(input string name, input logic sel, input logic [31:0] exp);
        md_if.MDSel = sel;
        #1;
        check(name, md_if.MDOut, exp);
        check({name, "_model"}, sel ? m_hi : m_lo, exp);
    endtask

    task automatic mt_write(input logic [2:0] op, input logic [31:0] a);
        md_if.MDWrite = 1'b1;
        md_if.MDOp    = op;
        md_if.A       = a;
        cyc(1);
        md_if.MDWrite = 1'b0;
    endtask

    // Launch one op and count Busy cycles; intrude drives Start/MDWrite while busy.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit intrude, output int n);
        md_if.Start   = 1'b1;
        md_if.MDWrite = 1'b1;
        md_if.MDOp    = op;
        md_if.A       = a;
        md_if.B       = b;
        cyc(1);
        md_if.Start   = 1'b0;
        md_if.MDWrite = 1'b0;
        n = 0;
        while (md_if.Busy && n < 40) begin
            if (intrude && n == 2) begin
                md_if.Start = 1'b1; md_if.MDWrite = 1'b1;
                md_if.MDOp = MD_MULT; md_if.A = 32'd3; md_if.B = 32'd4;
            end else if (intrude && n == 3) begin
                md_if.Start = 1'b0; md_if.MDOp = MD_MTLO; md_if.A = 32'hDEAD_BEEF;
            end else if (intrude && n == 4) begin
                md_if.MDWrite = 1'b0;
            end
            cyc(1);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        md_if.Start = 1'b0; md_if.MDOp = '0; md_if.MDWrite = 1'b0;
        md_if.MDSel = 1'b0; md_if.A = '0; md_if.B = '0;
        #1 reset = 1'b1;
        cyc(2);
        check("rst_busy", 32'(md_if.Busy), 32'd0);
        peek("rst_lo", 1'b0, 32'h0);
        peek("rst_hi", 1'b1, 32'h0);
        reset = 1'b0;
        cyc(1);

        run_op(MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, n);
        check("mult_busy_len", 32'(n), 32'd5);
        peek("mult_hi", 1'b1, 32'hFFFF_FFFF);
        peek("mult_lo", 1'b0, 32'hFFFF_FFFE);

        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, n);
        check("multu_busy_len", 32'(n), 32'd5);
        peek("multu_hi", 1'b1, 32'h0000_0001);
        peek("multu_lo", 1'b0, 32'hFFFF_FFFE);

        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, n);
        check("div_busy_len", 32'(n), 32'd10);
        peek("div_lo", 1'b0, 32'hFFFF_FFFD);
        peek("div_hi", 1'b1, 32'hFFFF_FFFF);

        run_op(MD_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0, n);
        check("divu_busy_len", 32'(n), 32'd10);
        peek("divu_lo", 1'b0, 32'h7FFF_FFFC);
        peek("divu_hi", 1'b1, 32'h0000_0001);

        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, n);
        check("div_ovf_busy_len", 32'(n), 32'd10);
        peek("div_ovf_lo", 1'b0, 32'h8000_0000);
        peek("div_ovf_hi", 1'b1, 32'h0000_0000);

        mt_write(MD_MTHI, 32'h1234_5678);
        mt_write(MD_MTLO, 32'h9ABC_DEF0);
        check("mt_busy", 32'(md_if.Busy), 32'd0);
        peek("mthi", 1'b1, 32'h1234_5678);
        peek("mtlo", 1'b0, 32'h9ABC_DEF0);

        // Start with an mt* opcode launches nothing and writes nothing.
        md_if.Start = 1'b1; md_if.MDWrite = 1'b1; md_if.MDOp = MD_MTLO; md_if.A = 32'h0000_FFFF;
        cyc(1);
        check("start_mt_busy", 32'(md_if.Busy), 32'd0);
        peek("start_mt_lo", 1'b0, 32'h9ABC_DEF0);

        md_if.MDWrite = 1'b0; md_if.MDOp = 3'b110; md_if.A = 32'd7; md_if.B = 32'd3;
        cyc(1);
        md_if.Start = 1'b0;
        check("op110_busy", 32'(md_if.Busy), 32'd0);
        peek("op110_hi", 1'b1, 32'h1234_5678);

        mt_write(MD_MTHI, 32'h55);
        mt_write(MD_MTLO, 32'h55);
        run_op(MD_DIV, 32'd100, 32'd0, 1'b1, n);
        check("div0_busy_len", 32'(n), 32'd10);
        check("div0_after_busy", 32'(md_if.Busy), 32'd0);
        peek("div0_hi", 1'b1, 32'h55);
        peek("div0_lo", 1'b0, 32'h55);

        md_if.Start = 1'b1; md_if.MDOp = MD_MULT; md_if.A = 32'd3; md_if.B = 32'd4;
        cyc(1);
        md_if.Start = 1'b0;
        cyc(1);
        check("rst_run_busy_before", 32'(md_if.Busy), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_run_busy", 32'(md_if.Busy), 32'd0);
        peek("rst_run_hi", 1'b1, 32'h0);
        peek("rst_run_lo", 1'b0, 32'h0);
        cyc(1);
        reset = 1'b0;
        cyc(6);
        check("post_rst_busy", 32'(md_if.Busy), 32'd0);
        peek("post_rst_hi", 1'b1, 32'h0);
        peek("post_rst_lo", 1'b0, 32'h0);

        run_op(MD_MULT, 32'd3, 32'd4, 1'b0, n);
        check("mult34_busy_len", 32'(n), 32'd5);
        peek("mult34_lo", 1'b0, 32'd12);
        peek("mult34_hi", 1'b1, 32'd0);

        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
